rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and forwarding unit for the RV32I register file. Shares the file's single write port among `NUM_REQ` write-back sources (ALU, load unit, CSR/debug) using round-robin arbitration with a valid/ready handshake. It registers the winning write into a one-stage write buffer and forwards that in-flight value to both read ports. It sits between the execute/memory write-back paths and `Register_File`, and drives its `WrEn`/`WrAddress`/`WrData` and consumes its `RdData1/2`.

## Interface
- `WIDTH`, 32, data width.
- `DEPTH_BITS`, 5, register address width.
- `NUM_REQ`, 3, number of write-back requesters (2..8).
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Req_Valid`  in  NUM_REQ  per-requester write request.
- `Req_Ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `Req_Addr`  in  NUM_REQ*DEPTH_BITS  packed destination addresses; requester i at bits [i*DEPTH_BITS +: DEPTH_BITS].
- `Req_Data`  in  NUM_REQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- `WrEn`  out  1  register-file write enable, registered.
- `WrAddress`  out  DEPTH_BITS  register-file write address, registered.
- `WrData`  out  WIDTH  register-file write data, registered.
- `RdAddress1`, `RdAddress2`  in  DEPTH_BITS  read addresses, also routed to the register file.
- `RfRdData1`, `RfRdData2`  in  WIDTH  raw register-file read data.
- `RdData1`, `RdData2`  out  WIDTH  forwarded read data to the datapath.

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1). The grant goes to the first requester with `Req_Valid` set, scanning from `ptr` upward and wrapping modulo NUM_REQ.
- `Req_Ready[i]` = 1 only for the granted requester. It is combinational from `Req_Valid` and `ptr`. A transfer completes when `Req_Valid[i] && Req_Ready[i]` at a rising edge.
- On a transfer from requester g:
  - `ptr <= (g+1) mod NUM_REQ`.
  - `WrAddress <= Req_Addr[g]` and `WrData <= Req_Data[g]`.
  - `WrEn <= (Req_Addr[g] != 0)`. A write to x0 is accepted but never committed.
- With no valid requester: `WrEn <= 0`, `ptr` holds, and `WrAddress`/`WrData` hold.
- Requesters must hold Valid/Addr/Data stable until Ready. The arbiter never drops an accepted request.
- Forwarding, applied independently per read port n:
  - If `RdAddressn == 0`, `RdDatan = 0`.
  - Else if `WrEn && WrAddress == RdAddressn`, `RdDatan = WrData`.
  - Otherwise `RdDatan = RfRdDatan`.
- Forwarding is purely combinational.
- Reset, asynchronous and with `RST` low: `ptr=0`, `WrEn=0`, `WrAddress=0`, `WrData=0`, all `Req_Ready=0`. `RdDatan` follows the forwarding rule with `WrEn=0`.
- Reset asserted mid-transfer: any buffered write is discarded and no RF write occurs. Requesters must re-present after reset.

## Timing
- Accept in cycle N. `WrEn` is high during cycle N+1, and the register file updates at the edge ending N+1.
- During N+1 the read ports see the new value via forwarding. From N+2 they see it from the file directly.
- Throughput: one write per cycle, sustained.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles. Maximum wait is NUM_REQ-1 cycles.
- Back-to-back writes to the same address from different requesters commit in grant order. The last one wins, and forwarding always shows the newest buffered value.

## Structure
- Package `rf_pkg` holds `WIDTH`, `DEPTH_BITS` and `NUM_REQ` defaults, plus constant `ZERO_REG = 0`.
- Sub-module `rr_arbiter` (parameter `N`) provides the Valid vector in, one-hot grant out, internal pointer and an advance-on-accept input. The top level holds the write buffer and forwarding muxes.

## Test plan
- **Reset:** hold `RST=0` with all Valid high → `Req_Ready=0`, `WrEn=0`. Release → first grant goes to requester 0.
- **Round-robin:** all three requesters valid for 6 cycles with distinct addresses 1/2/3 → grant order 0,1,2,0,1,2. `WrEn` is high on cycles 2..7 with matching `WrAddress`/`WrData`.
- **x0 suppression:** requester 1 writes `addr=0`, `data=0xDEADBEEF` → Ready is asserted, `WrEn` stays 0, and `RdData1` with `RdAddress1=0` reads 0.
- **Forwarding:** requester 0 writes x5=0x12345678 in cycle N, with `RdAddress2=5` and `RfRdData2=0` → `RdData2=0x12345678` in N+1. In N+2, `RdData2` equals the `RfRdData2` driven by the bench.
- **Same-address collision:** requester 0 writes x7=0xA, then requester 2 writes x7=0xB on consecutive grants → forwarded data is 0xA then 0xB, and the final register value is 0xB.
- **Reset mid-operation:** assert `RST` low while `WrEn=1` (x9 pending) → `WrEn` drops immediately and x9 is never written.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults for the register-file write-back arbiter.
package rf_pkg;
  localparam int WIDTH      = 32;
  localparam int DEPTH_BITS = 5;
  localparam int NUM_REQ    = 3;
  localparam int ZERO_REG   = 0;
  localparam int NUM_RD     = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from ptr, ptr advances past winner on accept.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] valid,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, ptr_nxt;

  always_comb begin
    int   idx;
    logic found;
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin grant, one-stage write buffer,
// and combinational forwarding of the buffered write to both read ports.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH      = rf_pkg::WIDTH,
  parameter int DEPTH_BITS = rf_pkg::DEPTH_BITS,
  parameter int NUM_REQ    = rf_pkg::NUM_REQ
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  output logic [NUM_REQ-1:0]            Req_Ready,
  input  logic [NUM_REQ*DEPTH_BITS-1:0] Req_Addr,
  input  logic [NUM_REQ*WIDTH-1:0]      Req_Data,
  output logic                          WrEn,
  output logic [DEPTH_BITS-1:0]         WrAddress,
  output logic [WIDTH-1:0]              WrData,
  input  logic [DEPTH_BITS-1:0]         RdAddress1,
  input  logic [DEPTH_BITS-1:0]         RdAddress2,
  input  logic [WIDTH-1:0]              RfRdData1,
  input  logic [WIDTH-1:0]              RfRdData2,
  output logic [WIDTH-1:0]              RdData1,
  output logic [WIDTH-1:0]              RdData2
);
  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [DEPTH_BITS-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  // Ready is held low while in reset so nothing is accepted before the pointer is sane.
  assign Req_Ready = grant & {NUM_REQ{RST}};
  assign xfer      = |(Req_Valid & Req_Ready);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .valid   (Req_Valid),
    .advance (xfer),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = Req_Addr[i*DEPTH_BITS +: DEPTH_BITS];
        sel_data = Req_Data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WrEn      <= 1'b0;
      WrAddress <= '0;
      WrData    <= '0;
    end else if (xfer) begin
      WrEn      <= (sel_addr != DEPTH_BITS'(ZERO_REG));
      WrAddress <= sel_addr;
      WrData    <= sel_data;
    end else begin
      WrEn      <= 1'b0;
    end
  end

  // Per-port forwarding: x0 reads zero, buffered write beats the stale file value.
  logic [NUM_RD-1:0][DEPTH_BITS-1:0] rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]      rf_data, rd_data;

  assign rd_addr = {RdAddress2, RdAddress1};
  assign rf_data = {RfRdData2, RfRdData1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_fwd
    always_comb begin
      if (rd_addr[p] == DEPTH_BITS'(ZERO_REG))     rd_data[p] = '0;
      else if (WrEn && (WrAddress == rd_addr[p]))  rd_data[p] = WrData;
      else                                         rd_data[p] = rf_data[p];
    end
  end

  assign RdData1 = rd_data[0];
  assign RdData2 = rd_data[1];
endmodule
